entropy_arbiter: RTL and testbench

ENTROPY_ARBITER -- requirements
Module: entropy_arbiter

---
 rtl/entropy_arbiter_pkg.sv | 26 ++
 rtl/entropy_arbiter_regs.sv | 100 ++++++++++
 rtl/entropy_arbiter.sv | 110 +++++++++++
 tb/tb_entropy_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/entropy_arbiter_pkg.sv
// Shared definitions for the entropy arbiter: register addresses, ID constants and FSM state type.
// The optional statistics counters are enabled by defining ENTROPY_ARBITER_STATS_EN.
package entropy_arbiter_pkg;

    localparam logic [7:0] ADDR_NAME0     = 8'h00;
    localparam logic [7:0] ADDR_NAME1     = 8'h01;
    localparam logic [7:0] ADDR_VERSION   = 8'h02;
    localparam logic [7:0] ADDR_CTRL      = 8'h10;
    localparam logic [7:0] ADDR_STATUS    = 8'h11;
    localparam logic [7:0] ADDR_CLEAR     = 8'h12;
    localparam logic [7:0] ADDR_STAT_SRC0 = 8'h20;
    localparam logic [7:0] ADDR_STAT_SRC1 = 8'h21;
    localparam logic [7:0] ADDR_STAT_TMO  = 8'h22;

    localparam logic [31:0] NAME0_VALUE   = 32'h656e7472;
    localparam logic [31:0] NAME1_VALUE   = 32'h61726220;
    localparam logic [31:0] VERSION_VALUE = 32'h302e3130;

    localparam logic [1:0] CTRL_RESET = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OUT  = 1'b1
    } state_t;

endpackage

// File: rtl/entropy_arbiter_regs.sv
// API register file: CTRL, sticky timeout flag, STATUS/ID readback and, with
// ENTROPY_ARBITER_STATS_EN defined, the word/timeout statistics counters.
module entropy_arbiter_regs
    import entropy_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    input  logic        out_valid,
    input  logic        rr_ptr,
    input  logic        src0_enabled,
    input  logic        src1_enabled,
    input  logic        timeout_set,
`ifdef ENTROPY_ARBITER_STATS_EN
    input  logic        word_src0,
    input  logic        word_src1,
`endif
    output logic [1:0]  ctrl_en,
    output logic        timeout_error,
    output logic [31:0] read_data,
    output logic        error
);

    logic        rd_hit;
    logic        wr_ok;
    logic [31:0] rd_value;
    logic        wr_ctrl;
    logic        wr_clear;
    logic        unused_write_data;

`ifdef ENTROPY_ARBITER_STATS_EN
    logic [31:0] stat_src0;
    logic [31:0] stat_src1;
    logic [31:0] stat_tmo;
`endif

    assign unused_write_data = ^write_data[31:2];

    always_comb begin
        rd_hit   = 1'b0;
        wr_ok    = 1'b0;
        rd_value = '0;
        case (address)
            ADDR_NAME0:   begin rd_hit = 1'b1; rd_value = NAME0_VALUE; end
            ADDR_NAME1:   begin rd_hit = 1'b1; rd_value = NAME1_VALUE; end
            ADDR_VERSION: begin rd_hit = 1'b1; rd_value = VERSION_VALUE; end
            ADDR_CTRL: begin
                rd_hit   = 1'b1;
                wr_ok    = 1'b1;
                rd_value = {30'd0, ctrl_en};
            end
            ADDR_STATUS: begin
                rd_hit   = 1'b1;
                rd_value = {27'd0, timeout_error, src1_enabled, src0_enabled, rr_ptr, out_valid};
            end
            ADDR_CLEAR:   wr_ok = 1'b1;
`ifdef ENTROPY_ARBITER_STATS_EN
            ADDR_STAT_SRC0: begin rd_hit = 1'b1; rd_value = stat_src0; end
            ADDR_STAT_SRC1: begin rd_hit = 1'b1; rd_value = stat_src1; end
            ADDR_STAT_TMO:  begin rd_hit = 1'b1; rd_value = stat_tmo; end
`endif
            default: ;
        endcase
    end

    assign read_data = (cs && !we && rd_hit) ? rd_value : 32'd0;
    assign error     = cs && (we ? !wr_ok : !rd_hit);
    assign wr_ctrl   = cs && we && (address == ADDR_CTRL);
    assign wr_clear  = cs && we && (address == ADDR_CLEAR) && write_data[0];

    // A timeout in the same cycle as a CLEAR write must not be lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en       <= CTRL_RESET;
            timeout_error <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_en <= write_data[1:0];
            if (timeout_set) timeout_error <= 1'b1;
            else if (wr_clear) timeout_error <= 1'b0;
        end
    end

`ifdef ENTROPY_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_src0 <= '0;
            stat_src1 <= '0;
            stat_tmo  <= '0;
        end else begin
            if (word_src0)   stat_src0 <= stat_src0 + 32'd1;
            if (word_src1)   stat_src1 <= stat_src1 + 32'd1;
            if (timeout_set) stat_tmo  <= stat_tmo + 32'd1;
        end
    end
`endif

endmodule

// File: rtl/entropy_arbiter.sv
// Two-source round-robin entropy arbiter with a one-word output register and hold timeout.
// Define ENTROPY_ARBITER_STATS_EN to add the statistics counters in the register file.
module entropy_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        error,
    input  logic        src0_enabled,
    input  logic [31:0] src0_data,
    input  logic        src0_valid,
    output logic        src0_ack,
    input  logic        src1_enabled,
    input  logic [31:0] src1_data,
    input  logic        src1_valid,
    output logic        src1_ack,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ack,
    output logic        out_src,
    output logic        timeout_error
);
    import entropy_arbiter_pkg::*;

    // Handshake: out_valid rises with the captured word and out_data/out_src stay
    // frozen until out_ack is sampled high while out_valid is high.
    state_t      state;
    logic        rr_ptr;
    logic [15:0] tmo_cnt;
    logic [1:0]  ctrl_en;
    logic [1:0]  eligible;
    logic        grant_valid;
    logic        grant_src;
    logic        timeout_set;

    assign eligible    = ctrl_en & {src1_enabled & src1_valid, src0_enabled & src0_valid};
    assign grant_valid = |eligible;
    assign timeout_set = (state == ST_OUT) && !out_ack && (tmo_cnt == TIMEOUT - 16'd1);

    always_comb begin
        grant_src = eligible[1];
        if (eligible == 2'b11) grant_src = rr_ptr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            src0_ack  <= 1'b0;
            src1_ack  <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            src0_ack <= 1'b0;
            src1_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state     <= ST_OUT;
                        out_valid <= 1'b1;
                        out_data  <= grant_src ? src1_data : src0_data;
                        out_src   <= grant_src;
                        src0_ack  <= !grant_src;
                        src1_ack  <= grant_src;
                        rr_ptr    <= !grant_src;
                        tmo_cnt   <= '0;
                    end
                end
                ST_OUT: begin
                    if (out_ack || timeout_set) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    entropy_arbiter_regs u_regs (
        .clk           (clk),
        .reset         (reset),
        .cs            (cs),
        .we            (we),
        .address       (address),
        .write_data    (write_data),
        .out_valid     (out_valid),
        .rr_ptr        (rr_ptr),
        .src0_enabled  (src0_enabled),
        .src1_enabled  (src1_enabled),
        .timeout_set   (timeout_set),
`ifdef ENTROPY_ARBITER_STATS_EN
        .word_src0     (src0_ack),
        .word_src1     (src1_ack),
`endif
        .ctrl_en       (ctrl_en),
        .timeout_error (timeout_error),
        .read_data     (read_data),
        .error         (error)
    );

endmodule

// File: tb/tb_entropy_arbiter.sv
// Randomised and directed bench for entropy_arbiter against a transaction-level model
// (held word kept in a queue, map decoded from the register table).
module tb_entropy_arbiter;

    localparam logic [15:0] TMO = 16'd16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        error;
    logic        src0_enabled, src0_valid, src0_ack;
    logic        src1_enabled, src1_valid, src1_ack;
    logic [31:0] src0_data, src1_data;
    logic [31:0] out_data;
    logic        out_valid, out_ack, out_src;
    logic        timeout_error;

    entropy_arbiter #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .cs            (cs),
        .we            (we),
        .address       (address),
        .write_data    (write_data),
        .read_data     (read_data),
        .error         (error),
        .src0_enabled  (src0_enabled),
        .src0_data     (src0_data),
        .src0_valid    (src0_valid),
        .src0_ack      (src0_ack),
        .src1_enabled  (src1_enabled),
        .src1_data     (src1_data),
        .src1_valid    (src1_valid),
        .src1_ack      (src1_ack),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ack       (out_ack),
        .out_src       (out_src),
        .timeout_error (timeout_error)
    );

    // clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: exp_q holds {src, data} of the word the consumer should see.
    logic [32:0] exp_q[$];
    int          m_age;
    bit          m_next;
    bit [1:0]    m_ctrl;
    bit          m_tmo;
    bit          m_ack0, m_ack1;
`ifdef ENTROPY_ARBITER_STATS_EN
    logic [31:0] m_cnt[3];
`endif

    function automatic void exp_api(output logic [31:0] rd, output logic err);
        bit readable;
        bit writable;
        logic [31:0] v;
        readable = 1'b0;
        writable = 1'b0;
        v = 32'd0;
        case (address)
            8'h00: begin readable = 1'b1; v = 32'h656e7472; end
            8'h01: begin readable = 1'b1; v = 32'h61726220; end
            8'h02: begin readable = 1'b1; v = 32'h302e3130; end
            8'h10: begin readable = 1'b1; writable = 1'b1; v = {30'd0, m_ctrl}; end
            8'h11: begin
                readable = 1'b1;
                v = {27'd0, m_tmo, src1_enabled, src0_enabled, m_next, exp_q.size() != 0};
            end
            8'h12: writable = 1'b1;
`ifdef ENTROPY_ARBITER_STATS_EN
            8'h20: begin readable = 1'b1; v = m_cnt[0]; end
            8'h21: begin readable = 1'b1; v = m_cnt[1]; end
            8'h22: begin readable = 1'b1; v = m_cnt[2]; end
`endif
            default: ;
        endcase
        rd  = (cs && !we && readable) ? v : 32'd0;
        err = cs && (we ? !writable : !readable);
    endfunction

    task automatic model_edge();
        bit e0, e1, pick, tmo_now, a0, a1;
        tmo_now = 1'b0;
        a0 = 1'b0;
        a1 = 1'b0;
        if (reset) begin
            exp_q.delete();
            m_age = 0; m_next = 1'b0; m_ctrl = 2'b11; m_tmo = 1'b0;
            m_ack0 = 1'b0; m_ack1 = 1'b0;
`ifdef ENTROPY_ARBITER_STATS_EN
            foreach (m_cnt[k]) m_cnt[k] = 32'd0;
`endif
            return;
        end
`ifdef ENTROPY_ARBITER_STATS_EN
        if (m_ack0) m_cnt[0] = m_cnt[0] + 32'd1;
        if (m_ack1) m_cnt[1] = m_cnt[1] + 32'd1;
`endif
        if (exp_q.size() != 0) begin
            if (out_ack) begin
                void'(exp_q.pop_front());
            end else if (m_age == int'(TMO)) begin
                void'(exp_q.pop_front());
                tmo_now = 1'b1;
`ifdef ENTROPY_ARBITER_STATS_EN
                m_cnt[2] = m_cnt[2] + 32'd1;
`endif
            end else begin
                m_age++;
            end
        end else begin
            e0 = m_ctrl[0] && src0_enabled && src0_valid;
            e1 = m_ctrl[1] && src1_enabled && src1_valid;
            if (e0 || e1) begin
                pick = (e0 && e1) ? m_next : e1;
                exp_q.push_back({pick, pick ? src1_data : src0_data});
                m_age  = 1;
                m_next = !pick;
                a0 = !pick;
                a1 = pick;
            end
        end
        m_ack0 = a0;
        m_ack1 = a1;
        if (cs && we && address == 8'h10) m_ctrl = write_data[1:0];
        if (tmo_now) m_tmo = 1'b1;
        else if (cs && we && address == 8'h12 && write_data[0]) m_tmo = 1'b0;
    endtask

    // One clock: advance the model with the inputs the DUT samples, then compare.
    task automatic step();
        logic [31:0] rd;
        logic        err;
        logic [32:0] head;
        model_edge();
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("src0_ack", 32'(src0_ack), 32'(m_ack0));
        check("src1_ack", 32'(src1_ack), 32'(m_ack1));
        check("timeout_error", 32'(timeout_error), 32'(m_tmo));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("out_data", out_data, head[31:0]);
            check("out_src", 32'(out_src), 32'(head[32]));
        end
        exp_api(rd, err);
        check("read_data", read_data, rd);
        check("error", 32'(error), 32'(err));
    endtask

    task automatic api_idle();
        cs = 1'b0; we = 1'b0; address = 8'h00; write_data = 32'd0;
    endtask

    task automatic api_access(input bit w, input logic [7:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output logic err);
        cs = 1'b1; we = w; address = a; write_data = d;
        #1;
        rd  = read_data;
        err = error;
        step();
        api_idle();
    endtask

    logic [31:0] rd;
    logic        err;
    int          held;
    logic [7:0]  addr_pool[10];

    initial begin
        addr_pool = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h40};
        reset = 1'b1;
        api_idle();
        src0_enabled = 1'b0; src0_valid = 1'b0; src0_data = 32'd0;
        src1_enabled = 1'b0; src1_valid = 1'b0; src1_data = 32'd0;
        out_ack = 1'b0;
        repeat (3) step();
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        reset = 1'b0;
        step();

        // register map and error decode
        api_access(1'b0, 8'h00, 32'd0, rd, err);
        check("name0", rd, 32'h656e7472);
        check("name0_err", 32'(err), 32'd0);
        api_access(1'b0, 8'h02, 32'd0, rd, err);
        check("version", rd, 32'h302e3130);
        check("version_err", 32'(err), 32'd0);
        api_access(1'b0, 8'h10, 32'd0, rd, err);
        check("ctrl_rst", rd, 32'd3);
        api_access(1'b1, 8'h00, 32'hffffffff, rd, err);
        check("wr_ro_err", 32'(err), 32'd1);
        api_access(1'b0, 8'h40, 32'd0, rd, err);
        check("unmapped_err", 32'(err), 32'd1);
        check("unmapped_rd", rd, 32'd0);
        api_access(1'b0, 8'h12, 32'd0, rd, err);
        check("rd_clear_err", 32'(err), 32'd1);
        api_access(1'b0, 8'h20, 32'd0, rd, err);
`ifdef ENTROPY_ARBITER_STATS_EN
        check("stat_map_err", 32'(err), 32'd0);
`else
        check("stat_unmapped_err", 32'(err), 32'd1);
        check("stat_unmapped_rd", rd, 32'd0);
`endif

        // both sources valid forever, consumer always ready
        src0_enabled = 1'b1; src1_enabled = 1'b1;
        src0_data = 32'h11223344; src1_data = 32'haabbccdd;
        src0_valid = 1'b1; src1_valid = 1'b1; out_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("alt_data", out_data, (i % 2 == 0) ? 32'h11223344 : 32'haabbccdd);
            check("alt_src", 32'(out_src), 32'(i % 2));
            step();
        end

        // CTRL masks src1 until re-enabled
        src0_valid = 1'b0; src1_valid = 1'b0;
        repeat (2) step();
        api_access(1'b1, 8'h10, 32'h1, rd, err);
        src1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("masked_ack", 32'(src1_ack), 32'd0);
            check("masked_valid", 32'(out_valid), 32'd0);
        end
        api_access(1'b1, 8'h10, 32'h2, rd, err);
        step();
        check("unmask_ack", 32'(src1_ack), 32'd1);
        check("unmask_data", out_data, 32'haabbccdd);

        // CTRL=0: no acks at all
        api_access(1'b1, 8'h10, 32'h0, rd, err);
        src0_valid = 1'b1;
        repeat (6) step();
        src0_valid = 1'b0; src1_valid = 1'b0;
        repeat (2) step();

        // hold timeout
        out_ack = 1'b0;
        api_access(1'b1, 8'h10, 32'h3, rd, err);
        src0_valid = 1'b1; src0_data = 32'hdeadbeef;
        step();
        src0_valid = 1'b0;
        held = 1;
        while (out_valid && held < 40) begin
            step();
            if (out_valid) held++;
        end
        check("tmo_cycles", 32'(held), 32'(TMO));
        api_access(1'b0, 8'h11, 32'd0, rd, err);
        check("status_tmo_set", 32'(rd[4]), 32'd1);
        api_access(1'b1, 8'h12, 32'h1, rd, err);
        api_access(1'b0, 8'h11, 32'd0, rd, err);
        check("status_tmo_clr", 32'(rd[4]), 32'd0);

        // timeout and CLEAR in the same cycle: set wins
        src0_valid = 1'b1;
        step();
        src0_valid = 1'b0;
        held = 0;
        while (m_age < int'(TMO) && held < 40) begin
            step();
            held++;
        end
        api_access(1'b1, 8'h12, 32'h1, rd, err);
        check("set_beats_clear", 32'(timeout_error), 32'd1);
        api_access(1'b1, 8'h12, 32'h1, rd, err);

        // clearing ctrl_en while OUT keeps the word
        src1_valid = 1'b1; src1_data = 32'h0badf00d;
        step();
        src1_valid = 1'b0;
        api_access(1'b1, 8'h10, 32'h0, rd, err);
        repeat (3) step();
        check("held_after_ctrl0", 32'(out_valid), 32'd1);
        check("held_data", out_data, 32'h0badf00d);
        out_ack = 1'b1;
        step();
        api_access(1'b1, 8'h10, 32'h3, rd, err);

        // reset while OUT
        out_ack = 1'b0;
        src0_valid = 1'b1;
        step();
        src0_valid = 1'b0;
        reset = 1'b1;
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        api_access(1'b0, 8'h10, 32'd0, rd, err);
        check("rst_ctrl", rd, 32'd3);
        api_access(1'b0, 8'h11, 32'd0, rd, err);
        check("rst_rr_ptr", 32'(rd[1]), 32'd0);
`ifdef ENTROPY_ARBITER_STATS_EN
        api_access(1'b0, 8'h20, 32'd0, rd, err);
        check("rst_stat0", rd, 32'd0);
        api_access(1'b0, 8'h22, 32'd0, rd, err);
        check("rst_stat_tmo", rd, 32'd0);
`endif

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            src0_enabled = ($urandom_range(0, 9) != 0);
            src1_enabled = ($urandom_range(0, 9) != 0);
            src0_valid   = ($urandom_range(0, 1) != 0);
            src1_valid   = ($urandom_range(0, 1) != 0);
            src0_data    = $urandom;
            src1_data    = $urandom;
            out_ack      = ($urandom_range(0, 3) != 0);
            reset        = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 19);
            if (r == 0) begin
                cs = 1'b1; we = 1'b1; address = 8'h10; write_data = 32'($urandom_range(0, 3));
            end else if (r == 1) begin
                cs = 1'b1; we = 1'b1; address = 8'h12; write_data = 32'($urandom_range(0, 1));
            end else if (r < 7) begin
                cs = 1'b1; we = ($urandom_range(0, 3) == 0);
                address = addr_pool[$urandom_range(0, 9)]; write_data = $urandom;
            end else begin
                api_idle();
            end
            step();
        end
        reset = 1'b0;
        api_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
